fifo_stream_reader: RTL

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader_if.sv | 37 +++
 rtl/fifo_stream_reader.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between fifo_stream_reader and its surroundings.
// The read side of an upstream FIFO (empty flag, read strobe, read data one cycle
// after the strobe) and the downstream valid/ready word stream with packet framing.
// Signal prefixes are from the reader's point of view: i_* into the reader, o_* out of it.
//   master : the reader itself
//   slave  : the FIFO plus downstream consumer driving/observing the reader
interface fifo_stream_reader_if #(
  parameter int unsigned DATA_W = 16
);
  logic              i_fifo_empty;
  logic              o_fifo_rd_en;
  logic [DATA_W-1:0] i_fifo_data;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_last;

  modport master (
    input  i_fifo_empty,
    input  i_fifo_data,
    input  i_ready,
    output o_fifo_rd_en,
    output o_valid,
    output o_data,
    output o_last
  );

  modport slave (
    output i_fifo_empty,
    output i_fifo_data,
    output i_ready,
    input  o_fifo_rd_en,
    input  o_valid,
    input  o_data,
    input  o_last
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Reads fixed-length packets out of a FIFO with one-cycle read latency and presents
// them as a valid/ready word stream with an end-of-packet marker.
// Dropping i_enable never truncates a packet: reading continues to the packet boundary.
//   clk, rst      : clock, asynchronous active-low reset
//   i_enable      : fetch packets while high, stop at the next packet boundary when low
//   bus           : FIFO read side and output stream (fifo_stream_reader_if.master)
//   o_pkt_cnt     : completed packets, wraps at 16 bits
//   o_busy        : FSM active, read in flight or words buffered
module fifo_stream_reader #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PKT_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  fifo_stream_reader_if.master bus,
  output logic [15:0]          o_pkt_cnt,
  output logic                 o_busy
);

  localparam int unsigned     IdxW    = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(PKT_LEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e            state_q, state_d;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [IdxW-1:0]   rd_idx_q, rd_idx_d;
  logic [IdxW-1:0]   out_idx_q, out_idx_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;

  logic       read_allowed;
  logic       rd_en;
  logic       valid;
  logic       pop;
  logic       push;
  logic [2:0] pending;

  assign valid   = (occ_q != 2'd0);
  assign pop     = valid && bus.i_ready;
  assign push    = inflight_q;
  assign pending = {1'b0, occ_q} + {2'b00, inflight_q};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_enable) state_d = StRun;
      end
      StRun: begin
        if (!i_enable) state_d = (rd_idx_q == '0) ? StIdle : StFinish;
      end
      StFinish: begin
        if (rd_en && (rd_idx_q == IdxLast)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs. A slot is free if the words already owned (buffered + in flight)
  // minus the one leaving this cycle leave room in the two-entry buffer; the pop term
  // makes this a combinational path from i_ready, which buys full throughput.
  always_comb begin
    read_allowed = 1'b0;
    unique case (state_q)
      StRun:    read_allowed = i_enable;
      StFinish: read_allowed = 1'b1;
      default:  read_allowed = 1'b0;
    endcase
    rd_en = read_allowed && !bus.i_fifo_empty && (pending < (3'd2 + {2'b00, pop}));
  end

  // Buffer and counter next-state. Head is the output word; tail only used when occ=2.
  always_comb begin
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = rd_en;
    rd_idx_d   = rd_idx_q;
    out_idx_d  = out_idx_q;
    pkt_cnt_d  = pkt_cnt_q;

    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = bus.i_fifo_data;
        else               tail_d = bus.i_fifo_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = bus.i_fifo_data;
        end else begin
          head_d = tail_q;
          tail_d = bus.i_fifo_data;
        end
      end
      default: ;
    endcase

    if (rd_en) rd_idx_d = (rd_idx_q == IdxLast) ? '0 : rd_idx_q + IdxW'(1);

    if (pop) begin
      out_idx_d = (out_idx_q == IdxLast) ? '0 : out_idx_q + IdxW'(1);
      if (out_idx_q == IdxLast) pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end

  // inflight clears on reset, so a word returned just after release is never captured
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      rd_idx_q   <= '0;
      out_idx_q  <= '0;
      pkt_cnt_q  <= 16'd0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      rd_idx_q   <= rd_idx_d;
      out_idx_q  <= out_idx_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign bus.o_fifo_rd_en = rd_en;
  assign bus.o_valid      = valid;
  assign bus.o_data       = valid ? head_q : '0;
  assign bus.o_last       = valid && (out_idx_q == IdxLast);
  assign o_pkt_cnt        = pkt_cnt_q;
  assign o_busy           = (state_q != StIdle) || inflight_q || (occ_q != 2'd0);

  // The read gating must make a returning word with a full, stalled buffer impossible
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(inflight_q && (occ_q == 2'd2) && !pop));

endmodule
